// File: rtl/spi_cmd_pkg.sv
// spi_cmd_pkg: shared definitions for the SPI command queue.
//  - FSM state encoding (localparams plus the enum built on them)
//  - level_w(): width of a FIFO occupancy count that can hold 0..depth
package spi_cmd_pkg;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_WLOW  = 3'd2;
  localparam logic [2:0] S_WHIGH = 3'd3;
  localparam logic [2:0] S_GAP   = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE  = S_IDLE,
    ST_START = S_START,
    ST_WLOW  = S_WLOW,
    ST_WHIGH = S_WHIGH,
    ST_GAP   = S_GAP
  } state_e;

  function automatic int level_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/spi_cmd_fifo.sv
// spi_cmd_fifo: synchronous FIFO with registered read data.
// Ports:
//  clk, rst        clock, synchronous active-high reset
//  wr_en, wr_data  push; ignored while full
//  rd_en           pop; ignored while empty; rd_data updates on the following cycle
//  rd_data         registered head word, held until the next pop
//  full, empty     occupancy flags
//  level           words currently stored (0..DEPTH)
module spi_cmd_fifo
  import spi_cmd_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        wr_en,
  input  logic [DATA_WIDTH-1:0]       wr_data,
  input  logic                        rd_en,
  output logic [DATA_WIDTH-1:0]       rd_data,
  output logic                        full,
  output logic                        empty,
  output logic [level_w(DEPTH)-1:0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = level_w(DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]         cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
  logic                  push, pop;

  assign full    = (cnt_q == LW'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign level   = cnt_q;
  assign rd_data = rd_data_q;

  always_comb begin
    push      = wr_en && !full;
    pop       = rd_en && !empty;
    // DEPTH is a power of two, so the pointers wrap for free.
    wr_ptr_d  = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d  = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    rd_data_d = pop  ? mem_q[rd_ptr_q] : rd_data_q;
    cnt_d     = cnt_q;
    if (push && !pop) cnt_d = cnt_q + 1'b1;
    else if (pop && !push) cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      cnt_q     <= '0;
      rd_data_q <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      cnt_q     <= cnt_d;
      rd_data_q <= rd_data_d;
    end
  end

  // Storage needs no reset: a slot is only read after it has been written.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/spi_cmd_queue.sv
// spi_cmd_queue: command-word feeder for a mode-0 SPI master.
// Buffers command words, launches one master frame per word, watches the
// master's chip select for frame start/end and returns each received word.
// Build option: define SPI_GAP_EN to insert GAP_CYCLES idle cycles after each
// frame (longer CS-high time between words).
// Ports:
//  clk, rst            clock, synchronous active-high reset
//  wr_en, wr_data      command push (dropped while full)
//  full, level, busy   queue status; level excludes the word in flight
//  rd_valid, rd_data   one-cycle strobe with the word received in the last frame
//  err_timeout         sticky: chip select never fell after a start
//  spi_start, data_send  to the master; data_send held from pop to end of frame
//  spi_cs, data_recv   from the master
// Handshake: one spi_start pulse per popped word; the frame is considered
// accepted when spi_cs goes low and complete when spi_cs returns high, at
// which point data_recv is captured.
module spi_cmd_queue
  import spi_cmd_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 8,
  parameter int START_TO   = 8,
  parameter int GAP_CYCLES = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic [DATA_WIDTH-1:0]      wr_data,
  output logic                       full,
  output logic [level_w(DEPTH)-1:0]  level,
  output logic                       busy,
  output logic                       rd_valid,
  output logic [DATA_WIDTH-1:0]      rd_data,
  output logic                       err_timeout,
  output logic                       spi_start,
  output logic [DATA_WIDTH-1:0]      data_send,
  input  logic                       spi_cs,
  input  logic [DATA_WIDTH-1:0]      data_recv
);

  // One counter serves both the start timeout and the inter-frame gap.
  localparam int CNT_W = $clog2(START_TO + GAP_CYCLES + 1);

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  rd_valid_q, rd_valid_d;
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
  logic                  err_q, err_d;
  logic                  fifo_rd_en;
  logic                  fifo_empty;

  // The FIFO's registered head doubles as data_send: it only changes on a
  // pop, and pops happen only in IDLE, so it is stable for the whole frame.
  spi_cmd_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_data (wr_data),
    .rd_en   (fifo_rd_en),
    .rd_data (data_send),
    .full    (full),
    .empty   (fifo_empty),
    .level   (level)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rd_valid_d = 1'b0;
    rd_data_d  = rd_data_q;
    err_d      = err_q;
    fifo_rd_en = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty && spi_cs) begin
          fifo_rd_en = 1'b1;
          state_d    = ST_START;
        end
      end
      ST_START: begin
        cnt_d   = '0;
        state_d = ST_WLOW;
      end
      ST_WLOW: begin
        if (!spi_cs) begin
          state_d = ST_WHIGH;
        end else if (cnt_q == CNT_W'(START_TO - 1)) begin
          // Master never took the frame: drop the word, no rd_valid.
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_WHIGH: begin
        if (spi_cs) begin
          rd_data_d  = data_recv;
          rd_valid_d = 1'b1;
`ifdef SPI_GAP_EN
          cnt_d      = '0;
          state_d    = ST_GAP;
`else
          state_d    = ST_IDLE;
`endif
        end
      end
      ST_GAP: begin
`ifdef SPI_GAP_EN
        if (cnt_q == CNT_W'(GAP_CYCLES - 1)) state_d = ST_IDLE;
        else cnt_d = cnt_q + 1'b1;
`else
        state_d = ST_IDLE;
`endif
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
      err_q      <= err_d;
    end
  end

  assign spi_start   = (state_q == ST_START);
  assign rd_valid    = rd_valid_q;
  assign rd_data     = rd_data_q;
  assign err_timeout = err_q;
  assign busy        = (state_q != ST_IDLE) || (level != '0);

endmodule
